// File: rtl/rk_kbd_pkg.sv
// Shared types and constants for the Radio-86RK keyboard matrix write scheduler.
// Key codes are {col, row}; script entries add a press bit on top.
package rk_kbd_pkg;

    typedef struct packed {
        logic [2:0] col;
        logic [3:0] row;
    } key_code_t;

    typedef struct packed {
        logic       press;
        logic [2:0] col;
        logic [3:0] row;
    } scr_entry_t;

    localparam logic [3:0] ROW_NONE  = 4'hF;
    localparam logic [7:0] SCR_PAUSE = 8'h00;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StIssue = 2'd2
    } sched_state_e;

    // Matrix positions of the keys used by the boot sequences.
    localparam key_code_t KEY_0     = '{col: 3'd0, row: 4'd2};
    localparam key_code_t KEY_1     = '{col: 3'd1, row: 4'd2};
    localparam key_code_t KEY_COMMA = '{col: 3'd4, row: 4'd3};
    localparam key_code_t KEY_G     = '{col: 3'd7, row: 4'd4};
    localparam key_code_t KEY_R     = '{col: 3'd2, row: 4'd6};
    localparam key_code_t KEY_CR    = '{col: 3'd2, row: 4'd1};

    function automatic scr_entry_t scr_key(input logic press, input key_code_t key);
        scr_entry_t e;
        e.press = press;
        e.col   = key.col;
        e.row   = key.row;
        return e;
    endfunction

    // "R0,10<CR>" as press/release pairs, first entry in the top byte.
    localparam int unsigned BOOT_R010_LEN = 12;
    localparam logic [BOOT_R010_LEN*8-1:0] BOOT_R010 = {
        8'hA6, 8'h26, 8'h82, 8'h02, 8'hC3, 8'h43,
        8'h92, 8'h12, 8'h82, 8'h02, 8'hA1, 8'h21
    };

    // "G<CR>".
    localparam int unsigned BOOT_G_LEN = 4;
    localparam logic [BOOT_G_LEN*8-1:0] BOOT_G = {8'hF4, 8'h74, 8'hA1, 8'h21};

endpackage

// File: rtl/rk_sync_fifo.sv
// Single-clock FIFO with drop-on-full pushes, synchronous flush and registered
// full/empty/count flags. Head entry is presented combinationally on dout.
module rk_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q && !flush;
    assign pop_ok  = pop && !empty_q && !flush;
    // A flush swallows the push without counting it as an overflow.
    assign dropped = push && full_q && !flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == COUNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/rk_kbd_sched.sv
// Arbitrates the keyboard matrix write port between live PS/2 key events and a
// tick-paced script queue. Live events always win; abort flushes and clears.
module rk_kbd_sched
    import rk_kbd_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 2000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   live_valid,
    input  logic                   live_press,
    input  logic [6:0]             live_code,
    input  logic                   scr_wr,
    input  logic [7:0]             scr_data,
    input  logic                   abort,
    output logic                   scr_full,
    output logic [$clog2(DEPTH):0] scr_count,
    output logic                   overflow,
    output logic                   script_active,
    output logic                   mat_we,
    output logic [3:0]             mat_row,
    output logic [2:0]             mat_col,
    output logic                   mat_val,
    output logic                   mat_clr
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // WAIT lasts TICK_DIV-1 cycles so that WAIT plus ISSUE spans one tick period.
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 2);

    sched_state_e   state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;

    logic           fifo_pop;
    logic           fifo_full, fifo_empty, fifo_dropped;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    scr_entry_t     head;
    key_code_t      live_key;
    logic           live_hit;
    logic           push_ok;

    logic           overflow_q, overflow_d;
    logic           active_q;
    logic           mat_we_q, mat_we_d;
    logic [3:0]     mat_row_q, mat_row_d;
    logic [2:0]     mat_col_q, mat_col_d;
    logic           mat_val_q, mat_val_d;
    logic           mat_clr_q, mat_clr_d;

    rk_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .push    (scr_wr),
        .din     (scr_data),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .dropped (fifo_dropped)
    );

    assign head     = scr_entry_t'(fifo_dout);
    assign live_key = key_code_t'(live_code);
    assign live_hit = live_valid && (live_key.row != ROW_NONE);
    assign push_ok  = scr_wr && !fifo_full;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StWait;
                    tick_d  = '0;
                end
            end
            StWait: begin
                if (tick_q == TICK_LAST) begin
                    state_d = StIssue;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StIssue: begin
                // Any live strobe, mapped or not, holds the step for a retry.
                if (!live_valid) begin
                    fifo_pop = 1'b1;
                    tick_d   = '0;
                    state_d  = (fifo_count == CW'(1) && !push_ok) ? StIdle : StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d  = StIdle;
            tick_d   = '0;
            fifo_pop = 1'b0;
        end
    end

    always_comb begin
        mat_we_d   = 1'b0;
        mat_row_d  = '0;
        mat_col_d  = '0;
        mat_val_d  = 1'b0;
        mat_clr_d  = 1'b0;
        overflow_d = overflow_q | fifo_dropped;
        if (abort) begin
            mat_clr_d  = 1'b1;
            overflow_d = 1'b0;
        end else if (live_hit) begin
            mat_we_d  = 1'b1;
            mat_row_d = live_key.row;
            mat_col_d = live_key.col;
            mat_val_d = live_press;
        end else if (fifo_pop && fifo_dout != SCR_PAUSE && head.row != ROW_NONE) begin
            mat_we_d  = 1'b1;
            mat_row_d = head.row;
            mat_col_d = head.col;
            mat_val_d = head.press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            overflow_q <= 1'b0;
            active_q   <= 1'b0;
            mat_we_q   <= 1'b0;
            mat_row_q  <= '0;
            mat_col_q  <= '0;
            mat_val_q  <= 1'b0;
            mat_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
            active_q   <= (state_d != StIdle);
            mat_we_q   <= mat_we_d;
            mat_row_q  <= mat_row_d;
            mat_col_q  <= mat_col_d;
            mat_val_q  <= mat_val_d;
            mat_clr_q  <= mat_clr_d;
        end
    end

    assign scr_full      = fifo_full;
    assign scr_count     = fifo_count;
    assign overflow      = overflow_q;
    assign script_active = active_q;
    assign mat_we        = mat_we_q;
    assign mat_row       = mat_row_q;
    assign mat_col       = mat_col_q;
    assign mat_val       = mat_val_q;
    assign mat_clr       = mat_clr_q;

endmodule
